matrix_row_scan_ctrl: RTL and testbench



---
 rtl/matrix_row_scan_ctrl_if.sv | 29 ++
 rtl/matrix_row_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_matrix_row_scan_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_row_scan_ctrl_if.sv
// Bundle of the scan controller's data-path signals.
//   en         : scan enable
//   sel_in     : requested preset select
//   row_data   : preset column data, row r in bits [5r+4:5r]
//   sel_out    : preset select latched by the controller
//   row_n      : active-low row drivers
//   col        : column data for the active row
//   frame_done : one-cycle pulse after the last row of a frame
// slave  : controller side (consumes en/sel_in/row_data)
// master : environment side (drives en/sel_in/row_data)
interface matrix_row_scan_ctrl_if;
  logic        en;
  logic [1:0]  sel_in;
  logic [34:0] row_data;
  logic [1:0]  sel_out;
  logic [6:0]  row_n;
  logic [4:0]  col;
  logic        frame_done;

  modport master (
    output en, sel_in, row_data,
    input  sel_out, row_n, col, frame_done
  );

  modport slave (
    input  en, sel_in, row_data,
    output sel_out, row_n, col, frame_done
  );
endinterface

// File: rtl/matrix_row_scan_ctrl.sv
// 7x5 LED matrix row scanner.
// Scans rows 0..6, each preceded by a blanking gap of BLANK_CYC cycles and
// driven for DIV cycles. The preset select is latched only when a scan starts
// and at the row-6 wrap, so one frame never mixes two presets.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous reset, active-high
//   bus : slave modport of matrix_row_scan_ctrl_if (en, sel_in, row_data in;
//         sel_out, row_n, col, frame_done out, all registered)
module matrix_row_scan_ctrl #(
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  matrix_row_scan_ctrl_if.slave  bus
);

  localparam int MAXC = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] C_DRV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_BLK_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [2:0]    r_row,   w_row_nxt;
  logic [1:0]    r_sel,   w_sel_nxt;
  logic [6:0]    r_row_n, w_row_n_nxt;
  logic [4:0]    r_col,   w_col_nxt;
  logic          r_fd,    w_fd_nxt;

  logic [2:0]    w_row_eff;
  logic [4:0]    w_row_cols;

  // Row 7 is unreachable; should it ever appear it behaves as row 0.
  assign w_row_eff = (r_row > 3'd6) ? 3'd0 : r_row;

  always_comb begin
    w_row_cols = '0;
    case (w_row_eff)
      3'd0: w_row_cols = bus.row_data[4:0];
      3'd1: w_row_cols = bus.row_data[9:5];
      3'd2: w_row_cols = bus.row_data[14:10];
      3'd3: w_row_cols = bus.row_data[19:15];
      3'd4: w_row_cols = bus.row_data[24:20];
      3'd5: w_row_cols = bus.row_data[29:25];
      3'd6: w_row_cols = bus.row_data[34:30];
      default: w_row_cols = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_sel_nxt   = r_sel;
    w_row_n_nxt = r_row_n;
    w_col_nxt   = r_col;
    w_fd_nxt    = 1'b0;

    if (!bus.en) begin
      // Disable wins over everything, including a simultaneous frame wrap.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_row_nxt   = '0;
      w_row_n_nxt = '1;
      w_col_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_sel_nxt   = bus.sel_in;
          w_row_nxt   = '0;
          w_cnt_nxt   = '0;
          w_row_n_nxt = '1;
          w_col_nxt   = '0;
        end
        S_BLANK: begin
          w_row_n_nxt = '1;
          w_col_nxt   = '0;
          if (r_cnt == C_BLK_LAST) begin
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = '0;
            w_row_nxt   = w_row_eff;
            w_row_n_nxt = ~(7'd1 << w_row_eff);
            w_col_nxt   = w_row_cols;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == C_DRV_LAST) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
            w_row_n_nxt = '1;
            w_col_nxt   = '0;
            if (w_row_eff == 3'd6) begin
              w_row_nxt = '0;
              w_fd_nxt  = 1'b1;
              w_sel_nxt = bus.sel_in;
            end else begin
              w_row_nxt = w_row_eff + 3'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_row_nxt   = '0;
          w_row_n_nxt = '1;
          w_col_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_sel   <= '0;
      r_row_n <= '1;
      r_col   <= '0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_sel   <= w_sel_nxt;
      r_row_n <= w_row_n_nxt;
      r_col   <= w_col_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign bus.sel_out    = r_sel;
  assign bus.row_n      = r_row_n;
  assign bus.col        = r_col;
  assign bus.frame_done = r_fd;

endmodule

// File: tb/tb_matrix_row_scan_ctrl.sv
// Scoreboarded bench: two scanners (defaults, and DIV=1/BLANK_CYC=3) share
// one stimulus stream. A timing model based on elapsed cycles since scan
// start predicts each cycle's outputs; a negedge monitor compares them.
module tb_matrix_row_scan_ctrl;

  logic clk;
  logic rst;
  logic        en_v;
  logic [1:0]  sel_v;
  logic [34:0] rd_v;

  matrix_row_scan_ctrl_if if0 ();
  matrix_row_scan_ctrl_if if1 ();

  assign if0.en = en_v;  assign if0.sel_in = sel_v;  assign if0.row_data = rd_v;
  assign if1.en = en_v;  assign if1.sel_in = sel_v;  assign if1.row_data = rd_v;

  matrix_row_scan_ctrl #(.DIV(4), .BLANK_CYC(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  matrix_row_scan_ctrl #(.DIV(1), .BLANK_CYC(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] row_n;
    logic [4:0] col;
    logic [1:0] sel;
    logic       fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int total = 0;
  int bad   = 0;

  // Reference model state, one slot per DUT.
  int         m_blank[2] = '{1, 3};
  int         m_per[2]   = '{5, 4};
  bit         m_run[2];
  int         m_s[2];
  logic [1:0] m_sel[2];
  logic [4:0] m_col[2];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 1'b0; m_s[d] = 0; m_sel[d] = 2'b00; m_col[d] = '0;
    end
  endfunction

  // One clock edge: s counts edges since the edge that started the scan.
  function automatic exp_t model_step(input int d);
    exp_t e;
    int p, r;
    e.fd = 1'b0;
    if (!en_v) begin
      m_run[d] = 1'b0;
    end else if (!m_run[d]) begin
      m_run[d] = 1'b1; m_s[d] = 0; m_sel[d] = sel_v;
    end else begin
      m_s[d]++;
      if (m_s[d] % (7 * m_per[d]) == 0) begin
        m_sel[d] = sel_v;
        e.fd = 1'b1;
      end
    end
    e.row_n = 7'h7F;
    e.col   = 5'd0;
    if (m_run[d]) begin
      p = m_s[d] % m_per[d];
      r = (m_s[d] / m_per[d]) % 7;
      if (p == m_blank[d]) m_col[d] = rd_v[5*r +: 5];
      if (p >= m_blank[d]) begin
        e.row_n = ~(7'd1 << r);
        e.col   = m_col[d];
      end
    end
    e.sel = m_sel[d];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    q0.push_back(model_step(0));
    q1.push_back(model_step(1));
    #1;
  endtask

  // Monitor: compares every queued prediction and the output invariants.
  always begin
    exp_t e;
    @(negedge clk);
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("d0_row_n", 32'(if0.row_n), 32'(e.row_n));
      check("d0_col", 32'(if0.col), 32'(e.col));
      check("d0_sel_out", 32'(if0.sel_out), 32'(e.sel));
      check("d0_frame_done", 32'(if0.frame_done), 32'(e.fd));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("d1_row_n", 32'(if1.row_n), 32'(e.row_n));
      check("d1_col", 32'(if1.col), 32'(e.col));
      check("d1_sel_out", 32'(if1.sel_out), 32'(e.sel));
      check("d1_frame_done", 32'(if1.frame_done), 32'(e.fd));
    end
    check("d0_one_low", 32'($countones(~if0.row_n) <= 1), 32'd1);
    check("d1_one_low", 32'($countones(~if1.row_n) <= 1), 32'd1);
    if (if0.row_n == 7'h7F) check("d0_col_blank", 32'(if0.col), 32'd0);
    if (if1.row_n == 7'h7F) check("d1_col_blank", 32'(if1.col), 32'd0);
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_d0_row_n"}, 32'(if0.row_n), 32'h7F);
    check({tag, "_d0_col"}, 32'(if0.col), 32'd0);
    check({tag, "_d0_sel"}, 32'(if0.sel_out), 32'd0);
    check({tag, "_d0_fd"}, 32'(if0.frame_done), 32'd0);
    check({tag, "_d1_row_n"}, 32'(if1.row_n), 32'h7F);
    check({tag, "_d1_col"}, 32'(if1.col), 32'd0);
    check({tag, "_d1_sel"}, 32'(if1.sel_out), 32'd0);
    check({tag, "_d1_fd"}, 32'(if1.frame_done), 32'd0);
  endtask

  // Advances until the model says DUT0 is driving row 'row'; bounded.
  task automatic run_to_drive_row(input int row, input string nm);
    int n;
    n = 0;
    while (!(m_run[0] && ((m_s[0] / m_per[0]) % 7 == row) &&
             (m_s[0] % m_per[0] >= m_blank[0])) && n < 200) begin
      step();
      n++;
    end
    check({nm, "_reached"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    model_reset();
    rst   = 1'b1;
    en_v  = 1'b1;
    sel_v = 2'b00;
    rd_v  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");

    // Full frame with row r carrying r+1, select 10.
    for (int r = 0; r < 7; r++) rd_v[5*r +: 5] = 5'(r + 1);
    sel_v = 2'b10;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (80) step();

    // Frame-boundary select change requested during row 3.
    en_v = 1'b0;
    repeat (2) step();
    sel_v = 2'b00;
    en_v  = 1'b1;
    step();
    run_to_drive_row(3, "row3");
    sel_v = 2'b11;
    rd_v  = {$urandom, $urandom};
    repeat (60) step();

    // Enable dropped while driving row 4, then restart.
    run_to_drive_row(4, "row4");
    en_v = 1'b0;
    repeat (3) step();
    en_v = 1'b1;
    repeat (25) step();

    // Asynchronous reset between edges while row 2 is driven.
    run_to_drive_row(2, "row2");
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    check_reset_vals("async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random traffic: rare disables, occasional select/data changes.
    for (int i = 0; i < 1500; i++) begin
      en_v = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 7) == 0) sel_v = 2'($urandom);
      if ($urandom_range(0, 9) == 0) rd_v = {$urandom, $urandom};
      step();
    end

    @(negedge clk);
    @(negedge clk);
    check("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
